// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle between the SCPU datapath and hazard_stall_ctrl.
//   master : datapath side, drives ID/EX/MEM hazard observations and
//            consumes the stall/flush/bubble controls.
//   slave  : hazard_stall_ctrl side.
// Signals:
//   id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used : source regs of ID insn
//   ex_rd_addr, ex_mem_read, ex_branch_taken         : EX insn info
//   mem_req, mem_ack                                  : MEM data access handshake
//   stall_if, stall_id, bubble_ex, flush_if_id, stall_all : pipeline controls
//   fsm_state (debug), perf_stall_cnt (CNT_W wide stall-cycle count)
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1_addr;
   logic [4:0]       id_rs2_addr;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       ex_rd_addr;
   logic             ex_mem_read;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ack;
   logic             stall_if;
   logic             stall_id;
   logic             bubble_ex;
   logic             flush_if_id;
   logic             stall_all;
   logic [1:0]       fsm_state;
   logic [CNT_W-1:0] perf_stall_cnt;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_rd_addr, ex_mem_read, ex_branch_taken, mem_req, mem_ack,
      input  stall_if, stall_id, bubble_ex, flush_if_id, stall_all,
             fsm_state, perf_stall_cnt
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             ex_rd_addr, ex_mem_read, ex_branch_taken, mem_req, mem_ack,
      output stall_if, stall_id, bubble_ex, flush_if_id, stall_all,
             fsm_state, perf_stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage SCPU datapath.
// Detects load-use hazards forwarding cannot cover, freezes the pipe while a
// MEM access waits for its ack, and squashes the wrong-path fetch on a taken
// branch. Controls are combinational from state and inputs.
// Ports:
//   clk   : rising-edge clock
//   rstn  : synchronous active-low reset; all outputs forced low while low
//   hz    : hazard_stall_ctrl_if.slave bundle (observations in, controls out)
// Parameters:
//   LOAD_USE_CYCLES : bubbles per load-use hazard (1..7)
//   CNT_W           : width of perf_stall_cnt
// Build option:
//   HAZARD_PERF_CNT_EN : when defined, perf_stall_cnt counts cycles with
//                        stall_id|stall_all (saturating); otherwise tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; evaluates mw > branch > load-use
// LU_STALL | inserting the remaining load-use bubbles (rem left)
// MEM_WAIT | MEM access outstanding, whole pipe frozen until ack
module hazard_stall_ctrl #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic               clk,
   input  logic               rstn,
   hazard_stall_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LU_STALL = 2'b01,
      MEM_WAIT = 2'b10
   } state_t;

   localparam logic [2:0] LU_REM = 3'(LOAD_USE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] rem, rem_nxt;
   logic       lu, mw;
   logic       s_if, s_id, bub, fl, s_all;

   assign lu = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
               ((hz.id_rs1_used && (hz.id_rs1_addr == hz.ex_rd_addr)) ||
                (hz.id_rs2_used && (hz.id_rs2_addr == hz.ex_rd_addr)));

   // An ack without a request carries no meaning, so it cannot end a wait.
   assign mw = hz.mem_req && !hz.mem_ack;

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      s_if      = 1'b0;
      s_id      = 1'b0;
      bub       = 1'b0;
      fl        = 1'b0;
      s_all     = 1'b0;
      case (state)
         // MEM_WAIT shares RUN's rules: the ack cycle resolves branch/lu at once.
         RUN, MEM_WAIT: begin
            if (mw) begin
               s_all     = 1'b1;
               state_nxt = MEM_WAIT;
            end else begin
               state_nxt = RUN;
               if (hz.ex_branch_taken) begin
                  // The ID instruction is squashed, so a load-use on it is moot.
                  fl  = 1'b1;
                  bub = 1'b1;
               end else if (lu) begin
                  s_if = 1'b1;
                  s_id = 1'b1;
                  bub  = 1'b1;
                  if (LOAD_USE_CYCLES > 1) begin
                     state_nxt = LU_STALL;
                     rem_nxt   = LU_REM;
                  end
               end
            end
         end
         LU_STALL: begin
            // EX holds a bubble here, so branch and lu cannot be live.
            if (mw) begin
               s_all = 1'b1;
            end else begin
               s_if    = 1'b1;
               s_id    = 1'b1;
               bub     = 1'b1;
               rem_nxt = rem - 3'd1;
               if (rem <= 3'd1) state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
            rem_nxt   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= RUN;
         rem   <= 3'd0;
      end else begin
         state <= state_nxt;
         rem   <= rem_nxt;
      end
   end

   assign hz.stall_if    = rstn & s_if;
   assign hz.stall_id    = rstn & s_id;
   assign hz.bubble_ex   = rstn & bub;
   assign hz.flush_if_id = rstn & fl;
   assign hz.stall_all   = rstn & s_all;
   assign hz.fsm_state   = rstn ? state : RUN;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] perf_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         perf_q <= '0;
      end else if ((s_id || s_all) && (perf_q != {CNT_W{1'b1}})) begin
         perf_q <= perf_q + CNT_W'(1);
      end
   end

   assign hz.perf_stall_cnt = rstn ? perf_q : {CNT_W{1'b0}};
`else
   assign hz.perf_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz1 ();
   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz3 ();

   hazard_stall_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rstn(rstn), .hz(hz1));
   hazard_stall_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(CNT_W)) dut3 (
      .clk(clk), .rstn(rstn), .hz(hz3));

   logic [6:0]       act  [2];
   logic [CNT_W-1:0] actp [2];
   assign act[0]  = {hz1.stall_if, hz1.stall_id, hz1.bubble_ex, hz1.flush_if_id,
                     hz1.stall_all, hz1.fsm_state};
   assign act[1]  = {hz3.stall_if, hz3.stall_id, hz3.bubble_ex, hz3.flush_if_id,
                     hz3.stall_all, hz3.fsm_state};
   assign actp[0] = hz1.perf_stall_cnt;
   assign actp[1] = hz3.perf_stall_cnt;

   typedef struct {
      int               dut;
      int               step_no;
      logic [6:0]       outs;
      logic [CNT_W-1:0] perf;
   } exp_t;

   exp_t   q[$];
   int     checks = 0;
   int     errors = 0;
   int     step_cnt = 0;

   // Reference model: outstanding bubble count, memory-wait flag, stall tally.
   int     luc     [2] = '{1, 3};
   int     pend    [2];
   bit     waiting [2];
   longint perf    [2];
   longint perf_max = (longint'(1) << CNT_W) - 1;

   task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input bit mr, input bit br, input bit req, input bit ack);
      bit lu, mw, sif, sid, bub, fl, sa;
      logic [1:0] st;
      exp_t e;
      @(posedge clk);
      #1;
      rstn = r;
      hz1.id_rs1_addr = rs1; hz3.id_rs1_addr = rs1;
      hz1.id_rs2_addr = rs2; hz3.id_rs2_addr = rs2;
      hz1.id_rs1_used = u1;  hz3.id_rs1_used = u1;
      hz1.id_rs2_used = u2;  hz3.id_rs2_used = u2;
      hz1.ex_rd_addr  = rd;  hz3.ex_rd_addr  = rd;
      hz1.ex_mem_read = mr;  hz3.ex_mem_read = mr;
      hz1.ex_branch_taken = br; hz3.ex_branch_taken = br;
      hz1.mem_req = req; hz3.mem_req = req;
      hz1.mem_ack = ack; hz3.mem_ack = ack;
      step_cnt++;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      mw = req && !ack;
      for (int d = 0; d < 2; d++) begin
         e.dut = d;
         e.step_no = step_cnt;
         if (!r) begin
            e.outs = '0;
            e.perf = '0;
            q.push_back(e);
            pend[d] = 0; waiting[d] = 0; perf[d] = 0;
            continue;
         end
         sif = 0; sid = 0; bub = 0; fl = 0; sa = 0;
         st = (pend[d] > 0) ? 2'b01 : (waiting[d] ? 2'b10 : 2'b00);
         if (pend[d] > 0) begin
            if (mw) sa = 1;
            else begin sif = 1; sid = 1; bub = 1; pend[d]--; end
         end else if (mw) begin
            sa = 1; waiting[d] = 1;
         end else begin
            waiting[d] = 0;
            if (br) begin fl = 1; bub = 1; end
            else if (lu) begin sif = 1; sid = 1; bub = 1; pend[d] = luc[d] - 1; end
         end
         e.outs = {sif, sid, bub, fl, sa, st};
`ifdef HAZARD_PERF_CNT_EN
         e.perf = perf[d][CNT_W-1:0];
`else
         e.perf = '0;
`endif
         q.push_back(e);
         if ((sid || sa) && perf[d] < perf_max) perf[d]++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle the DUTs present their controls; compare against queue.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (act[e.dut] !== e.outs) begin
            errors++;
            $display("FAIL outs dut_luc%0d step %0d: got %b expected %b (if,id,bub,flush,all,state)",
                     luc[e.dut], e.step_no, act[e.dut], e.outs);
         end
         checks++;
         if (actp[e.dut] !== e.perf) begin
            errors++;
            $display("FAIL perf dut_luc%0d step %0d: got %0d expected %0d",
                     luc[e.dut], e.step_no, actp[e.dut], e.perf);
         end
      end
   end

   initial begin
      hz1.id_rs1_addr = 0; hz3.id_rs1_addr = 0;
      hz1.id_rs2_addr = 0; hz3.id_rs2_addr = 0;
      hz1.id_rs1_used = 0; hz3.id_rs1_used = 0;
      hz1.id_rs2_used = 0; hz3.id_rs2_used = 0;
      hz1.ex_rd_addr  = 0; hz3.ex_rd_addr  = 0;
      hz1.ex_mem_read = 0; hz3.ex_mem_read = 0;
      hz1.ex_branch_taken = 0; hz3.ex_branch_taken = 0;
      hz1.mem_req = 0; hz3.mem_req = 0;
      hz1.mem_ack = 0; hz3.mem_ack = 0;
      for (int d = 0; d < 2; d++) begin pend[d] = 0; waiting[d] = 0; perf[d] = 0; end

      // reset
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use on rs1 (x5)
      step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
      idle(4);
      // load into x0 never hazards
      step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      idle(1);
      // memory wait of 3 cycles then ack
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(1);
      // branch beats load-use (rs2 match)
      step(1, 0, 7, 0, 1, 7, 1, 1, 0, 0);
      idle(2);
      // load-use then two wait cycles inside the bubble sequence
      step(1, 9, 9, 1, 1, 9, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(5);
      // ack-cycle with load-use pending in ID
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 3, 0, 1, 0, 3, 1, 0, 1, 1);
      idle(4);
      // ack without request is ignored
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
      // reset during a memory wait
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);

      // randomized traffic; small register range so matches are frequent
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(99) >= 2),
              5'($urandom_range(3)), 5'($urandom_range(3)),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              5'($urandom_range(3)),
              ($urandom_range(99) < 50), ($urandom_range(99) < 15),
              ($urandom_range(99) < 30), ($urandom_range(99) < 45));
      end
      idle(2);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
